poly_note_player: RTL

POLY_NOTE_PLAYER -- requirements
Module: poly_note_player

---
 rtl/poly_note_player.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/poly_note_player.sv
// Polyphonic square-wave note player: NUM_VOICES tone voices with hold timers, retrigger/allocate/steal
// assignment and a PWM mixer. Define POLY_NOTE_RELEASE_EN to add the explicit note-release ports.
module poly_note_player #(
   parameter int NUM_VOICES = 4,
   parameter int DIV_WIDTH = 13,
   parameter int HOLD_WIDTH = 24,
   parameter logic [HOLD_WIDTH-1:0] HOLD_CYCLES = 24'd5000000
) (
   input  logic                  iClk,
   input  logic                  iReset,
   input  logic                  iNoteValid,
   input  logic [DIV_WIDTH-1:0]  iNoteDiv,
`ifdef POLY_NOTE_RELEASE_EN
   input  logic                  iNoteRelease,
   input  logic [DIV_WIDTH-1:0]  iReleaseDiv,
`endif
   output logic                  oPWM,
   output logic [NUM_VOICES-1:0] oActive
);

   localparam int PTR_W = $clog2(NUM_VOICES);
   localparam int LVL_W = $clog2(NUM_VOICES + 1);

   logic [DIV_WIDTH-1:0]  r_div  [NUM_VOICES];
   logic [DIV_WIDTH-1:0]  r_cnt  [NUM_VOICES];
   logic [HOLD_WIDTH-1:0] r_hold [NUM_VOICES];
   logic [NUM_VOICES-1:0] r_phase;
   logic [NUM_VOICES-1:0] r_active;
   logic [PTR_W-1:0]      r_stealPtr;
   logic [PTR_W-1:0]      r_pwmCnt;
   logic                  r_pwm;

   logic                  w_reqOk;
   logic                  w_matchHit;
   logic                  w_freeHit;
   logic                  w_stealAdv;
   logic [PTR_W-1:0]      w_matchIdx;
   logic [PTR_W-1:0]      w_freeIdx;
   logic [NUM_VOICES-1:0] w_load;
   logic [NUM_VOICES-1:0] w_retrig;
   logic [NUM_VOICES-1:0] w_release;
   logic [NUM_VOICES-1:0] w_expire;
   logic [NUM_VOICES-1:0] w_wrap;
   logic [LVL_W-1:0]      w_level;

   // Voice selection: the descending scans leave the lowest matching/free index selected.
   always_comb begin
      w_reqOk    = iNoteValid && (iNoteDiv >= DIV_WIDTH'(2));
      w_matchHit = 1'b0;
      w_matchIdx = '0;
      w_freeHit  = 1'b0;
      w_freeIdx  = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (r_active[i] && (r_div[i] == iNoteDiv)) begin
            w_matchHit = 1'b1;
            w_matchIdx = PTR_W'(i);
         end
         if (!r_active[i]) begin
            w_freeHit = 1'b1;
            w_freeIdx = PTR_W'(i);
         end
      end
      w_load     = '0;
      w_retrig   = '0;
      w_stealAdv = 1'b0;
      if (w_reqOk) begin
         if (w_matchHit) begin
            w_retrig[w_matchIdx] = 1'b1;
         end else if (w_freeHit) begin
            w_load[w_freeIdx] = 1'b1;
         end else begin
            w_load[r_stealPtr] = 1'b1;
            w_stealAdv         = 1'b1;
         end
      end
   end

   always_comb begin
      w_wrap    = '0;
      w_expire  = '0;
      w_release = '0;
      w_level   = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         w_wrap[i]   = (r_cnt[i] == (r_div[i] - DIV_WIDTH'(1)));
         w_expire[i] = r_active[i] && (r_hold[i] == HOLD_WIDTH'(1));
`ifdef POLY_NOTE_RELEASE_EN
         w_release[i] = iNoteRelease && r_active[i] && (r_div[i] == iReleaseDiv);
`endif
         w_level = w_level + LVL_W'(r_active[i] & r_phase[i]);
      end
   end

   // A trigger outranks release and expiry; a retrigger only refreshes hold so the tone keeps running.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_div[i]  <= '0;
            r_cnt[i]  <= '0;
            r_hold[i] <= '0;
         end
         r_phase  <= '0;
         r_active <= '0;
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (w_load[i]) begin
               r_div[i]    <= iNoteDiv;
               r_cnt[i]    <= '0;
               r_phase[i]  <= 1'b0;
               r_hold[i]   <= HOLD_CYCLES;
               r_active[i] <= 1'b1;
            end else if (w_retrig[i] || (r_active[i] && !w_release[i] && !w_expire[i])) begin
               r_hold[i] <= w_retrig[i] ? HOLD_CYCLES : (r_hold[i] - HOLD_WIDTH'(1));
               if (w_wrap[i]) begin
                  r_cnt[i]   <= '0;
                  r_phase[i] <= ~r_phase[i];
               end else begin
                  r_cnt[i] <= r_cnt[i] + DIV_WIDTH'(1);
               end
            end else if (r_active[i]) begin
               r_active[i] <= 1'b0;
               r_phase[i]  <= 1'b0;
               r_cnt[i]    <= '0;
               r_hold[i]   <= '0;
            end
         end
      end
   end

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         r_stealPtr <= '0;
         r_pwmCnt   <= '0;
         r_pwm      <= 1'b0;
      end else begin
         if (w_stealAdv) begin
            r_stealPtr <= (r_stealPtr == PTR_W'(NUM_VOICES - 1)) ? '0 : (r_stealPtr + PTR_W'(1));
         end
         r_pwmCnt <= (r_pwmCnt == PTR_W'(NUM_VOICES - 1)) ? '0 : (r_pwmCnt + PTR_W'(1));
         r_pwm    <= (LVL_W'(r_pwmCnt) < w_level);
      end
   end

   assign oPWM    = r_pwm;
   assign oActive = r_active;

endmodule
